sub_rr_arbiter: RTL and testbench

- Shares one subtractor datapath (a - b, DATAWIDTH bits) between NREQ requesters.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- One registered result slot, tagged with the winning requester index.
- Sits between the processing units and the shared SUB datapath; the combinational subtractor is instantiated internally and the difference is registered here.

---
 rtl/sub_rr_arbiter.sv | 102 ++++++++++
 tb/tb_sub_rr_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_rr_arbiter.sv
// Round-robin arbiter sharing one registered a-b subtractor between NREQ requesters.
// Optional macro SUB_SATURATE_EN clamps the difference to zero on borrow.
module sub_rr_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int IDXW      = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATAWIDTH-1:0]      res_diff,
  output logic                      res_borrow,
  output logic [IDXW-1:0]           res_tag
);

  logic [IDXW-1:0]      ptr_q;
  logic [IDXW-1:0]      ptr_d;
  logic [IDXW-1:0]      gnt_idx;
  logic [NREQ-1:0]      grant;
  logic                 can_issue;
  logic                 issue;
  logic [DATAWIDTH-1:0] sel_a;
  logic [DATAWIDTH-1:0] sel_b;
  logic [DATAWIDTH-1:0] diff_raw;
  logic [DATAWIDTH-1:0] diff_out;
  logic                 borrow;

  assign can_issue = ~res_valid | res_ready;

  // Scan from the pointer upward with wrap-around; first valid requester wins.
  always_comb begin
    int   cand;
    logic found;
    cand    = 0;
    found   = 1'b0;
    grant   = '0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!found && ((req_valid & (NREQ'(1) << cand)) != '0)) begin
        found   = 1'b1;
        grant   = NREQ'(1) << cand;
        gnt_idx = IDXW'(cand);
      end
    end
  end

  // Reset gating keeps req_ready low while Rst is held, even with an empty slot.
  assign req_ready = grant & {NREQ{can_issue & Rst}};
  assign issue     = |req_ready;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*DATAWIDTH +: DATAWIDTH];
        sel_b = req_b[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign {borrow, diff_raw} = {1'b0, sel_a} - {1'b0, sel_b};

`ifdef SUB_SATURATE_EN
  assign diff_out = borrow ? '0 : diff_raw;
`else
  assign diff_out = diff_raw;
`endif

  always_comb begin
    if (int'(gnt_idx) == NREQ - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr_q      <= '0;
      res_valid  <= 1'b0;
      res_diff   <= '0;
      res_borrow <= 1'b0;
      res_tag    <= '0;
    end else if (issue) begin
      ptr_q      <= ptr_d;
      res_valid  <= 1'b1;
      res_diff   <= diff_out;
      res_borrow <= borrow;
      res_tag    <= gnt_idx;
    end else if (res_valid && res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sub_rr_arbiter.sv
// Directed self-checking bench for sub_rr_arbiter (4 requesters, 8-bit operands).
module tb_sub_rr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             Clk;
  logic             Rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR-1:0]    req_ready;
  logic             res_valid;
  logic             res_ready;
  logic [DW-1:0]    res_diff;
  logic             res_borrow;
  logic [IW-1:0]    res_tag;

  int checks = 0;
  int passed = 0;

  sub_rr_arbiter #(
    .DATAWIDTH(DW),
    .NREQ     (NR),
    .IDXW     (IW)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_diff  (res_diff),
    .res_borrow(res_borrow),
    .res_tag   (res_tag)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic load_default_ops();
    for (int i = 0; i < NR; i++) set_op(i, DW'(100 + 10 * i), DW'(i));
  endtask

  // Expected order starting from pointer 1: 1,2,3,0; diff_i = 100 + 9*i.
  logic [NR-1:0] exp_gnt [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int            exp_tag [4] = '{1, 2, 3, 0};
  int            exp_dif [4] = '{109, 118, 127, 100};

  initial begin
    Rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;

    // Reset state, ready held low even with requests present.
    step();
    req_valid = 4'b1111;
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_diff", res_diff, 0);
    check("rst_res_borrow", res_borrow, 0);
    check("rst_res_tag", res_tag, 0);
    check("rst_req_ready", req_ready, 0);

    // Single requester.
    step();
    Rst       = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 8'd50, 8'd20);
    #1;
    check("t1_req_ready", req_ready, 4'b0001);
    step();
    check("t1_res_valid", res_valid, 1);
    check("t1_res_diff", res_diff, 30);
    check("t1_res_borrow", res_borrow, 0);
    check("t1_res_tag", res_tag, 0);

    // Pop without issue: valid drops, payload holds.
    req_valid = '0;
    res_ready = 1'b1;
    step();
    check("pop_res_valid", res_valid, 0);
    check("pop_res_diff", res_diff, 30);
    check("pop_res_tag", res_tag, 0);

    // Round-robin with all requesters valid, pointer at 1.
    load_default_ops();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_ready_%0d", k), req_ready, exp_gnt[k]);
      step();
      check($sformatf("rr_valid_%0d", k), res_valid, 1);
      check($sformatf("rr_tag_%0d", k), res_tag, exp_tag[k]);
      check($sformatf("rr_diff_%0d", k), res_diff, exp_dif[k]);
    end

    // Backpressure: slot holds tag 0 / diff 100, pointer at 1.
    res_ready = 1'b0;
    req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_ready_%0d", k), req_ready, 0);
      check($sformatf("bp_diff_%0d", k), res_diff, 100);
      check($sformatf("bp_tag_%0d", k), res_tag, 0);
      check($sformatf("bp_valid_%0d", k), res_valid, 1);
      step();
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 4'b0010);
    step();
    check("bp_release_tag", res_tag, 1);
    check("bp_release_diff", res_diff, 109);

    // Borrow and wrap via requester 2 (pointer now 2).
    req_valid = 4'b0100;
    set_op(2, 8'd5, 8'd9);
    #1;
    check("brw_ready", req_ready, 4'b0100);
    step();
`ifdef SUB_SATURATE_EN
    check("brw_diff", res_diff, 0);
`else
    check("brw_diff", res_diff, 8'hFC);
`endif
    check("brw_borrow", res_borrow, 1);
    check("brw_tag", res_tag, 2);

    // Simultaneous pop and issue, requester 3.
    req_valid = 4'b1000;
    set_op(3, 8'd200, 8'd1);
    #1;
    check("pi_ready", req_ready, 4'b1000);
    step();
    check("pi_valid", res_valid, 1);
    check("pi_diff", res_diff, 199);
    check("pi_borrow", res_borrow, 0);
    check("pi_tag", res_tag, 3);

    // Equal operands on requester 1 (pointer 0 -> first valid is 1), pointer becomes 2.
    req_valid = 4'b0010;
    set_op(1, 8'd9, 8'd9);
    step();
    check("eq_diff", res_diff, 0);
    check("eq_borrow", res_borrow, 0);
    check("eq_tag", res_tag, 1);

    // Asynchronous reset between edges with slot full and pointer at 2.
    req_valid = '0;
    res_ready = 1'b0;
    #2;
    Rst       = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("ar_res_valid", res_valid, 0);
    check("ar_res_diff", res_diff, 0);
    check("ar_res_tag", res_tag, 0);
    check("ar_req_ready", req_ready, 0);
    step();
    Rst       = 1'b1;
    res_ready = 1'b1;
    load_default_ops();
    #1;
    check("ar_first_grant", req_ready, 4'b0001);
    step();
    check("ar_tag", res_tag, 0);
    check("ar_diff", res_diff, 100);

    // Idle cycles must not move the pointer (still 1).
    req_valid = '0;
    step();
    step();
    req_valid = 4'b1111;
    #1;
    check("idle_grant", req_ready, 4'b0010);
    step();
    check("idle_tag", res_tag, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
